// File: rtl/pm_sorter_pipe_pkg.sv
// rtl/pm_sorter_pipe_pkg.sv - shared constants and width helpers for the path-metric sorter
// Purpose: default PM width and list size, the all-ones PM sentinel, and the
// index / active-count width helpers used by pm_sorter_pipe and pm_rank_unit.
package pm_sorter_pipe_pkg;

  localparam int PM_WIDTH_DEF = 8;
  localparam int L_DEF        = 4;

  // Sentinel written into empty output slots, at the default PM width.
  localparam logic [PM_WIDTH_DEF-1:0] PM_MAX_DEF = '1;

  // Width of a candidate index for a list of size l (2*l candidates).
  function automatic int idx_width(input int l);
    return $clog2(2 * l);
  endfunction

  // Width of the active-path count, which must be able to hold l itself.
  function automatic int na_width(input int l);
    return $clog2(l) + 1;
  endfunction

endpackage

// File: rtl/pm_rank_unit.sv
// rtl/pm_rank_unit.sv - combinational rank of one candidate PM among all eligible candidates
// Purpose: rank of candidate CIDX = number of eligible candidates strictly smaller,
// plus number of eligible lower-indexed candidates with an equal PM. Ties
// therefore resolve to the lower index and ranks are unique across eligibles.
// Ports:
//   i_pm_all  all N candidate PMs, candidate j in [j*PM_WIDTH +: PM_WIDTH]
//   i_elig    eligibility flag per candidate
//   o_rank    rank of candidate CIDX (meaningful only when it is itself eligible)
module pm_rank_unit
  import pm_sorter_pipe_pkg::*;
#(
  parameter int PM_WIDTH = PM_WIDTH_DEF,
  parameter int N        = 2 * L_DEF,
  parameter int IDX_W    = $clog2(N),
  parameter int CIDX     = 0
) (
  input  logic [PM_WIDTH*N-1:0] i_pm_all,
  input  logic [N-1:0]          i_elig,
  output logic [IDX_W:0]        o_rank
);

  logic [PM_WIDTH-1:0] w_pm_self;

  assign w_pm_self = i_pm_all[CIDX*PM_WIDTH +: PM_WIDTH];

  always_comb begin
    o_rank = '0;
    for (int j = 0; j < N; j++) begin
      if (i_elig[j]) begin
        if ((i_pm_all[j*PM_WIDTH +: PM_WIDTH] < w_pm_self) ||
            ((j < CIDX) && (i_pm_all[j*PM_WIDTH +: PM_WIDTH] == w_pm_self))) begin
          o_rank = o_rank + (IDX_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pm_sorter_pipe.sv
// rtl/pm_sorter_pipe.sv - two-stage elastic sorter returning the L smallest of 2L path metrics
// Purpose: stage 1 ranks every eligible candidate, stage 2 scatters candidates
// into output slots by rank. Valid/ready flow control, active-path clamp and
// synchronous flush.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   flush        synchronous clear of both stage valids; blocks input acceptance
//   in_valid     pm_in / n_active valid
//   in_ready     input accepted this cycle when in_valid is also high
//   pm_in        2L candidates, candidate c in [c*PM_WIDTH +: PM_WIDTH]
//   n_active     live parent paths (1..L); 0 or >L treated as L
//   out_valid    pm_out / idx_out / slot_mask valid
//   out_ready    downstream accepts
//   pm_out       L smallest PMs ascending, slot 0 smallest; empty slots all ones
//   idx_out      source candidate index per slot; empty slots 0
//   slot_mask    bit s set when slot s holds a real survivor
module pm_sorter_pipe
  import pm_sorter_pipe_pkg::*;
#(
  parameter int  PM_WIDTH = PM_WIDTH_DEF,
  parameter int  L        = L_DEF,
  localparam int IDX_W    = idx_width(L),
  localparam int NA_W     = na_width(L)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PM_WIDTH*2*L-1:0] pm_in,
  input  logic [NA_W-1:0]         n_active,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PM_WIDTH*L-1:0]   pm_out,
  output logic [IDX_W*L-1:0]      idx_out,
  output logic [L-1:0]            slot_mask
);

  localparam int                  N      = 2 * L;
  localparam logic [PM_WIDTH-1:0] PM_MAX = '1;
  localparam logic [NA_W-1:0]     L_NA   = NA_W'(L);

  // Input side
  logic [NA_W-1:0] w_n_eff;
  logic [N-1:0]    w_elig;
  logic [IDX_W:0]  w_rank [N];

  // Flow control
  logic w_s1_load;
  logic w_s2_load;
  logic r_s1_valid;
  logic r_s2_valid;

  // Stage 1 registers
  logic [PM_WIDTH*N-1:0] r_s1_pm;
  logic [IDX_W:0]        r_s1_rank [N];
  logic [N-1:0]          r_s1_elig;

  // Stage 2 scatter result and registers
  logic [PM_WIDTH*L-1:0] w_s2_pm;
  logic [IDX_W*L-1:0]    w_s2_idx;
  logic [L-1:0]          w_s2_mask;
  logic [PM_WIDTH*L-1:0] r_pm_out;
  logic [IDX_W*L-1:0]    r_idx_out;
  logic [L-1:0]          r_slot_mask;

  // Illegal active counts fall back to a full list.
  assign w_n_eff = ((n_active == '0) || (n_active > L_NA)) ? L_NA : n_active;

  // Each live parent contributes two children, so candidates 0..2*n-1 are live.
  always_comb begin
    w_elig = '0;
    for (int c = 0; c < N; c++) begin
      w_elig[c] = (c < 2 * int'(w_n_eff));
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_rank
    pm_rank_unit #(
      .PM_WIDTH (PM_WIDTH),
      .N        (N),
      .IDX_W    (IDX_W),
      .CIDX     (c)
    ) u_rank (
      .i_pm_all (pm_in),
      .i_elig   (w_elig),
      .o_rank   (w_rank[c])
    );
  end

  // Elastic two-stage handshake: stage 2 drains when the consumer takes its
  // word or it is empty; stage 1 accepts when it is empty or moving on.
  assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready  = ~flush & (~r_s1_valid | w_s2_load);
  assign w_s1_load = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_pm   <= '0;
      r_s1_elig <= '0;
      for (int c = 0; c < N; c++) begin
        r_s1_rank[c] <= '0;
      end
    end else if (w_s1_load) begin
      r_s1_pm   <= pm_in;
      r_s1_elig <= w_elig;
      for (int c = 0; c < N; c++) begin
        r_s1_rank[c] <= w_rank[c];
      end
    end
  end

  // Ranks are unique among eligibles, so at most one candidate matches a slot.
  // A slot with no match is exactly a slot index >= 2*n_active.
  always_comb begin
    w_s2_pm   = {L{PM_MAX}};
    w_s2_idx  = '0;
    w_s2_mask = '0;
    for (int s = 0; s < L; s++) begin
      for (int c = 0; c < N; c++) begin
        if (r_s1_elig[c] && (r_s1_rank[c] == (IDX_W+1)'(s))) begin
          w_s2_pm[s*PM_WIDTH +: PM_WIDTH] = r_s1_pm[c*PM_WIDTH +: PM_WIDTH];
          w_s2_idx[s*IDX_W +: IDX_W]      = IDX_W'(c);
          w_s2_mask[s]                    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm_out    <= '0;
      r_idx_out   <= '0;
      r_slot_mask <= '0;
    end else if (w_s2_load) begin
      r_pm_out    <= w_s2_pm;
      r_idx_out   <= w_s2_idx;
      r_slot_mask <= w_s2_mask;
    end
  end

  assign out_valid = r_s2_valid;
  assign pm_out    = r_pm_out;
  assign idx_out   = r_idx_out;
  assign slot_mask = r_slot_mask;

endmodule

// File: doc/pm_sorter_pipe.md
Name: pm_sorter_pipe

Overview:
Pipelined, parametrised successor to the combinational path-metric sorter used in the SCL decoder. It takes 2L candidate PMs from the path-extension stage and returns the L smallest, in ascending order, together with each winner's source candidate index. It adds valid/ready flow control, an active-path count for early decoding stages where fewer than L paths exist, and a synchronous flush for frame abort. It sits between PM update and the path-survivor/pointer-copy logic.

Parameters:
PM_WIDTH, 8, unsigned PM bit width.
L, 4, list size; legal values 2, 4, 8.
IDX_W, $clog2(2*L), width of a candidate index (derived; do not override).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline clear.
in_valid  in  1  pm_in and n_active are valid.
in_ready  out  1  block accepts the input this cycle.
pm_in  in  PM_WIDTH*2*L  candidate c in bits [c*PM_WIDTH +: PM_WIDTH], c = 0..2L-1.
n_active  in  $clog2(L)+1  number of live parent paths, 1..L.
out_valid  out  1  outputs valid.
out_ready  in  1  downstream accepts.
pm_out  out  PM_WIDTH*L  slot s in [s*PM_WIDTH +: PM_WIDTH]; slot 0 is the smallest.
idx_out  out  IDX_W*L  source candidate index per slot.
slot_mask  out  L  bit s = slot s holds a real survivor.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid flags, out_valid, pm_out, idx_out and slot_mask clear to 0. in_ready reads 1 once reset is released.
- Eligibility: candidate c is eligible iff c < 2*n_active. n_active=0 or n_active>L is illegal; clamp to L.
- Stage 1 (registered): for each eligible c, rank[c] = count of eligible j with pm[j] < pm[c], plus count of eligible j < c with pm[j] == pm[c]. Ties therefore go to the lower index, and ranks are unique. Register pm, rank and eligibility.
- Stage 2 (registered): slot s takes the eligible candidate with rank == s. If there is none, pm_out slot = all ones, idx_out slot = 0, and mask bit = 0. slot_mask = (1 << min(2*n_active, L)) - 1.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 per cycle.
- Flow control, elastic 2-stage pipeline:
  - s2_load = s1_valid & (!s2_valid | out_ready)
  - s1_load = in_valid & in_ready
  - in_ready = !flush & (!s1_valid | s2_load)
- Outputs are held stable while out_valid & !out_ready. No loss and no duplication under any stall pattern.
- Flush: on a clock edge with flush=1, both stage valids clear. Data registers may keep stale values. Flush overrides a simultaneous in_valid (not accepted) and a simultaneous out_ready (the current output is dropped).
- Arithmetic: unsigned compares only; no saturation inside this block. Rank counters are IDX_W+1 bits wide.
- Reset mid-operation: all in-flight results are discarded; no output appears after release until new input is accepted.

Decomposition:
- Shared package/defines: PM_WIDTH default, L, IDX_W, and the PM_MAX constant (all ones).
- One natural sub-module, pm_rank_unit: combinational rank of one candidate against all 2L. It is instantiated 2L times inside stage 1. The scatter and the flow control stay in the top level.

Test Plan:
1. L=4, n_active=4, pm_in c0..c7 = 3,9,5,6,1,20,7,8 → after 2 cycles: pm_out = 1,3,5,6; idx_out = 4,0,2,3; slot_mask = 1111.
2. All eight candidates = 5 → pm_out = 5,5,5,5; idx_out = 0,1,2,3 (tie rule).
3. n_active=1, c0=3, c1=9, others = 0 (ineligible) → pm_out = 3,9,FF,FF; idx_out = 0,1,0,0; slot_mask = 0011. n_active=2 with c0..c3 = 4,7,2,2 → pm_out = 2,2,4,7; idx_out = 2,3,0,1.
4. Back-to-back inputs A..F with out_ready low for cycles 3–5 → in_ready drops while both stages are full. Outputs A..F emerge in order, each exactly once, and stay stable while stalled.
5. Flush asserted with in_valid=1 and both stages full → in_ready=0 that cycle, out_valid=0 next cycle, and the next accepted input appears 2 cycles later.
6. rst_n pulsed low asynchronously mid-stream → out_valid and pm_out are 0 immediately; after release, nothing is output until a new input arrives. Repeat cases 1 and 4 with L=2 and L=8.
